// File: rtl/bcd_pkg.sv
// Shared definitions for the keypad decimal entry and BCD conversion paths.
// Key codes, FSM state encoding, default sizes and the shared x10 helper.
package bcd_pkg;

    localparam int DIGITS_DEF = 5;
    localparam int WIDTH_DEF  = 16;
    localparam int ACC_W      = 17;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } state_t;

    // Shift-and-add multiply keeps the accumulator step free of a hard multiplier.
    function automatic logic [ACC_W-1:0] times10(input logic [ACC_W-1:0] a);
        return (a << 3) + (a << 1);
    endfunction

endpackage

// File: rtl/decimal_to_binary.sv
// Keypad decimal entry buffer with a serial BCD-to-binary converter.
// Digits shift into a right-justified BCD buffer; enter converts MSD first, one digit per cycle.
module decimal_to_binary
    import bcd_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int WIDTH  = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [2:0]            ndigits,
    output logic [WIDTH-1:0]      value,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] MAX_DIGITS = 3'(DIGITS);
    localparam logic [2:0] LAST_IDX   = 3'(DIGITS - 1);

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [2:0]          ndigits_q, ndigits_d;
    logic [WIDTH-1:0]    value_q, value_d;
    logic                overflow_q, overflow_d;
    logic                done_q, done_d;
    logic                fresh_q, fresh_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [2:0]          idx_q, idx_d;

    logic [3:0]          curDigit;
    logic [ACC_W-1:0]    accNext;
    logic                isDigit;

    assign curDigit = bcd_q[4*idx_q +: 4];
    assign accNext  = times10(acc_q) + ACC_W'(curDigit);
    assign isDigit  = (key_code <= 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bcd_q      <= '0;
            ndigits_q  <= '0;
            value_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            fresh_q    <= 1'b0;
            acc_q      <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            ndigits_q  <= ndigits_d;
            value_q    <= value_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            fresh_q    <= fresh_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
        end
    end

    // Keys are only examined in IDLE, so anything strobed while busy is simply lost.
    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        ndigits_d  = ndigits_q;
        value_d    = value_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        fresh_d    = fresh_q;
        acc_d      = acc_q;
        idx_d      = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    if (isDigit) begin
                        if (fresh_q) begin
                            bcd_d     = {{(4*DIGITS-4){1'b0}}, key_code};
                            ndigits_d = 3'd1;
                            fresh_d   = 1'b0;
                        end else if (ndigits_q < MAX_DIGITS) begin
                            bcd_d     = {bcd_q[4*DIGITS-5:0], key_code};
                            ndigits_d = ndigits_q + 3'd1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        bcd_d      = '0;
                        ndigits_d  = '0;
                        value_d    = '0;
                        overflow_d = 1'b0;
                        fresh_d    = 1'b0;
                    end else if (key_code == KEY_BACK) begin
                        if (ndigits_q != 3'd0) begin
                            bcd_d     = bcd_q >> 4;
                            ndigits_d = ndigits_q - 3'd1;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        acc_d   = '0;
                        idx_d   = LAST_IDX;
                        state_d = ST_CONVERT;
                    end
                end
            end

            ST_CONVERT: begin
                acc_d = accNext;
                idx_d = idx_q - 3'd1;
                if (idx_q == 3'd0) begin
                    overflow_d = (accNext > ACC_W'({WIDTH{1'b1}}));
                    value_d    = overflow_d ? {WIDTH{1'b1}} : accNext[WIDTH-1:0];
                    done_d     = 1'b1;
                    fresh_d    = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bcd      = bcd_q;
    assign ndigits  = ndigits_q;
    assign value    = value_q;
    assign overflow = overflow_q;
    assign busy     = (state_q == ST_CONVERT);
    assign done     = done_q;

endmodule

// File: tb/tb_decimal_to_binary.sv
// Scoreboard bench for decimal_to_binary: enter pushes the expected result,
// a monitor pops and compares it whenever done pulses.
module tb_decimal_to_binary;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [19:0] bcd;
    logic [2:0]  ndigits;
    logic [15:0] value;
    logic        overflow;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] value;
        logic        overflow;
        logic [19:0] bcd;
        logic [2:0]  ndigits;
        int          doneCyc;
    } exp_t;

    exp_t sbQ[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    decimal_to_binary dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_valid(key_valid),
        .key_code (key_code),
        .bcd      (bcd),
        .ndigits  (ndigits),
        .value    (value),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // One-cycle key strobe; an enter with a given expectation queues it for the monitor.
    task automatic applyStimulus(input logic [3:0] code, input bit pushExp = 1'b0,
                                 input logic [15:0] expVal = '0, input logic expOv = 1'b0,
                                 input logic [19:0] expBcd = '0, input logic [2:0] expNd = '0);
        exp_t e;
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        if (pushExp) begin
            e.value    = expVal;
            e.overflow = expOv;
            e.bcd      = expBcd;
            e.ndigits  = expNd;
            e.doneCyc  = cyc + 1 + 5;
            sbQ.push_back(e);
        end
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'hC;
    endtask

    task automatic waitDone();
        int n = 0;
        while (sbQ.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (sbQ.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL done_timeout: pending=%0d, expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sbQ.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sbQ.pop_front();
                checkOutput("done_cycle", cyc, e.doneCyc);
                checkOutput("value", value, e.value);
                checkOutput("overflow", overflow, e.overflow);
                checkOutput("bcd_after", bcd, e.bcd);
                checkOutput("ndigits_after", ndigits, e.ndigits);
                checkOutput("busy_at_done", busy, 0);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (3) @(negedge clk);
        checkOutput("rst_bcd", bcd, 0);
        checkOutput("rst_ndigits", ndigits, 0);
        checkOutput("rst_value", value, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 12345, sixth digit ignored
        for (int i = 1; i <= 6; i++) applyStimulus(4'(i));
        checkOutput("full_bcd", bcd, 20'h12345);
        checkOutput("full_ndigits", ndigits, 5);
        applyStimulus(4'hF, 1'b1, 16'h3039, 1'b0, 20'h12345, 3'd5);
        waitDone();

        // 65535 fits; fresh entry auto-clears the old buffer
        applyStimulus(4'd6);
        checkOutput("fresh_bcd", bcd, 20'h00006);
        checkOutput("fresh_ndigits", ndigits, 1);
        applyStimulus(4'd5); applyStimulus(4'd5); applyStimulus(4'd3); applyStimulus(4'd5);
        applyStimulus(4'hF, 1'b1, 16'hFFFF, 1'b0, 20'h65535, 3'd5);
        waitDone();

        // 65536 overflows and saturates
        applyStimulus(4'd6); applyStimulus(4'd5); applyStimulus(4'd5); applyStimulus(4'd3); applyStimulus(4'd6);
        applyStimulus(4'hF, 1'b1, 16'hFFFF, 1'b1, 20'h65536, 3'd5);
        waitDone();

        applyStimulus(4'hA);
        checkOutput("clr_value", value, 0);
        checkOutput("clr_overflow", overflow, 0);
        checkOutput("clr_ndigits", ndigits, 0);
        checkOutput("clr_bcd", bcd, 0);

        applyStimulus(4'hB);
        checkOutput("bs_empty_bcd", bcd, 0);
        checkOutput("bs_empty_ndigits", ndigits, 0);

        applyStimulus(4'd1); applyStimulus(4'd2); applyStimulus(4'd3);
        applyStimulus(4'hB); applyStimulus(4'd4);
        checkOutput("bs_bcd", bcd, 20'h00124);
        checkOutput("bs_ndigits", ndigits, 3);
        applyStimulus(4'hF, 1'b1, 16'h007C, 1'b0, 20'h00124, 3'd3);
        waitDone();

        applyStimulus(4'hA);
        applyStimulus(4'hF, 1'b1, 16'h0000, 1'b0, 20'h00000, 3'd0);
        waitDone();

        // Digit strobed while busy must be dropped
        applyStimulus(4'd4); applyStimulus(4'd2);
        applyStimulus(4'hF, 1'b1, 16'h002A, 1'b0, 20'h00042, 3'd2);
        checkOutput("busy_high", busy, 1);
        applyStimulus(4'd9);
        waitDone();
        applyStimulus(4'hC); applyStimulus(4'hD); applyStimulus(4'hE);
        checkOutput("cde_bcd", bcd, 20'h00042);
        checkOutput("cde_ndigits", ndigits, 2);
        checkOutput("cde_value", value, 16'h002A);
        checkOutput("cde_busy", busy, 0);

        // Reset mid-conversion: no expectation queued, so any done is flagged
        applyStimulus(4'hF);
        checkOutput("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_value", value, 0);
        checkOutput("abort_bcd", bcd, 0);
        checkOutput("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("abort_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
